sram_read_streamer: RTL and testbench

- Read client placed directly upstream of the SRAM arbiter's read port (r0/r1). It turns a {base, count} burst command into a stream of word addresses and collects the returned 32-bit words.
- Returned words are presented in order on a valid/ready output stream, with a last marker on the final word.
- Credit-based flow control bounds in-flight reads, so returned data can always be buffered locally.
- Used by SIFT stages to fetch image rows from SRAM.

---
 rtl/sram_stream_pkg.sv | 24 ++
 rtl/sync_stream_fifo.sv | 57 +++++
 rtl/sram_read_streamer.sv | 141 ++++++++++++++
 tb/tb_sram_read_streamer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_pkg.sv
// Shared definitions for the SRAM streaming clients (read and write side).
//   - default address/data widths of the SRAM word port
//   - burst FSM state encoding
//   - bit-field offsets of the arbiter's {mask, addr, data} request word
package sram_stream_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 32;

    // Request word layout used by the arbiter: {mask, addr, data}, data at LSB.
    localparam int MASK_W   = DATA_W_DEF / 8;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = DATA_LSB + DATA_W_DEF;
    localparam int MASK_LSB = ADDR_LSB + ADDR_W_DEF;
    localparam int REQ_W    = MASK_LSB + MASK_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_stream_fifo.sv
// Single-clock FIFO with registered storage, used to buffer SRAM words.
// A word pushed in one cycle is readable on pop_data from the next cycle;
// there is no combinational push->pop bypass.
// Ports:
//   clock, reset_n     clock and synchronous active-low reset
//   push, push_data    write side (ignored when full)
//   pop                read side (ignored when empty); pop_data shows head
//   full, empty, count occupancy status
module sync_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/sram_read_streamer.sv
// Burst read client for the SRAM arbiter read port.
// Accepts {base, count}, issues count word addresses (wrapping modulo
// 2^ADDR_W), buffers returned words and streams them out in order with a
// last marker. Issue is credit limited so the local FIFO can never overflow.
// Ports:
//   clock, reset_n                        clock, synchronous active-low reset
//   cmd_valid/ready, cmd_base, cmd_count  burst command
//   addr_valid/ready, addr                read address request
//   rdata_valid/ready, rdata              returned words
//   out_valid/ready, out_data, out_last   output stream
//   busy, done                            status (done: one-cycle pulse)
module sram_read_streamer
    import sram_stream_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_count,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    input  logic              rdata_valid,
    output logic              rdata_ready,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] to_issue_q;
    logic [ADDR_W-1:0] delivered_q;
    // outstanding: issued but not yet accepted downstream (credit usage).
    // pending: issued but not yet returned; gates which rdata beats belong
    // to the current burst so stray returns are dropped.
    logic [CW-1:0]     outstanding_q;
    logic [CW-1:0]     pending_q;

    logic              cmd_hs;
    logic              issue_hs;
    logic              push;
    logic              deliver;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign cmd_hs      = cmd_valid && cmd_ready;
    assign issue_hs    = addr_valid && addr_ready;
    assign deliver     = out_valid && out_ready;
    assign push        = rdata_valid && rdata_ready && (pending_q != '0);
    assign rdata_ready = !fifo_full;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign addr      = ptr_q;
    assign out_valid = !fifo_empty;
    assign out_last  = out_valid && (delivered_q == count_q - ADDR_W'(1));

    sync_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (rdata),
        .pop       (deliver),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            count_q       <= '0;
            ptr_q         <= '0;
            to_issue_q    <= '0;
            delivered_q   <= '0;
            outstanding_q <= '0;
            pending_q     <= '0;
        end else begin
            state         <= state_nx;
            outstanding_q <= outstanding_q + CW'(issue_hs) - CW'(deliver);
            pending_q     <= pending_q + CW'(issue_hs) - CW'(push);
            if (cmd_hs) begin
                ptr_q       <= cmd_base;
                count_q     <= cmd_count;
                to_issue_q  <= cmd_count;
                delivered_q <= '0;
            end else begin
                if (issue_hs) begin
                    ptr_q      <= ptr_q + ADDR_W'(1);
                    to_issue_q <= to_issue_q - ADDR_W'(1);
                end
                if (deliver) delivered_q <= delivered_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        addr_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_nx = (cmd_count == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                addr_valid = (to_issue_q != '0) &&
                             (outstanding_q < CW'(MAX_OUTSTANDING));
                if (addr_valid && addr_ready && to_issue_q == ADDR_W'(1))
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (delivered_q == count_q) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Buffered words are a subset of the credited ones.
    a_fifo_bound: assert property (@(posedge clock) disable iff (!reset_n)
        fifo_count <= outstanding_q);

endmodule

// File: tb/tb_sram_read_streamer.sv
module tb_sram_read_streamer;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int MO = 8;
    localparam int LAT = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_base, cmd_count;
    logic          addr_valid, addr_ready;
    logic [AW-1:0] addr;
    logic          rdata_valid, rdata_ready;
    logic [DW-1:0] rdata;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          out_last, busy, done;

    always #5 clock = ~clock;

    sram_read_streamer #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    typedef struct { logic [DW-1:0] d; logic l; } exp_t;
    typedef struct { logic [AW-1:0] a; int due; } arb_t;

    exp_t          exp_out[$];
    logic [AW-1:0] exp_addr[$];
    arb_t          arb_q[$];

    int tests = 0, fails = 0;
    int cyc = 0;
    int n_addr = 0, n_out = 0, n_done = 0, done_cyc = 0;
    logic prev_done = 1'b0;
    bit ar_rand = 0;
    int or_mode = 0;   // 0: always ready, 1: never ready, 2: random

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[13:0], a} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Arbiter and downstream model: drive just after the edge.
    always begin
        @(posedge clock); #1;
        addr_ready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 1) != 0);
        endcase
        if (arb_q.size() != 0 && arb_q[0].due <= cyc) begin
            rdata_valid = 1'b1;
            rdata       = mem_word(arb_q[0].a);
        end else begin
            rdata_valid = 1'b0;
            rdata       = '0;
        end
    end

    // Monitor: sample handshakes mid-cycle.
    always @(negedge clock) begin
        if (rdata_valid) begin
            if (!rdata_ready) chk("rdata_ready_while_valid", rdata_ready, 1);
            else arb_q.delete(0);
        end
        if (addr_valid && addr_ready) begin
            arb_q.push_back('{a: addr, due: cyc + LAT});
            if (reset_n) begin
                n_addr++;
                if (exp_addr.size() == 0) chk("addr_unexpected", addr, -1);
                else chk("addr", addr, exp_addr.pop_front());
            end
        end
        if (!reset_n) begin
            exp_addr.delete();
            exp_out.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_out.size() == 0) chk("out_unexpected", out_data, -1);
                else begin
                    exp_t e;
                    e = exp_out.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_width", prev_done, 0);
            end
        end
        prev_done = done;
    end

    task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] n,
                            output int acc_cyc);
        int t;
        logic [AW-1:0] a;
        t = 0;
        @(posedge clock); #1;
        while (!cmd_ready && t < 200) begin @(posedge clock); #1; t++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            exp_addr.push_back(a);
            exp_out.push_back('{d: mem_word(a), l: (i == int'(n) - 1)});
        end
        cmd_valid = 1'b1; cmd_base = b; cmd_count = n;
        acc_cyc = cyc;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, t;
        d0 = n_done; t = 0;
        while (n_done == d0 && t < budget) begin @(negedge clock); t++; end
        @(negedge clock); @(negedge clock);
        chk({name, "_done_count"}, n_done - d0, 1);
        chk({name, "_busy_idle"}, busy, 0);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        chk({name, "_all_delivered"}, exp_out.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        chk({name, "_addr_valid"}, addr_valid, 0);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rdata_ready"}, rdata_ready, 1);
    endtask

    initial begin
        int a0, o0, acc, t;
        reset_n = 0; cmd_valid = 0; cmd_base = '0; cmd_count = '0;
        addr_ready = 1; out_ready = 1; rdata_valid = 0; rdata = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        @(negedge clock);
        check_reset_outputs("reset");

        // Basic burst
        a0 = n_addr; o0 = n_out;
        send_cmd(18'h00100, 18'd4, acc);
        wait_done("basic", 200);
        chk("basic_addrs", n_addr - a0, 4);
        chk("basic_words", n_out - o0, 4);

        // Credit limit
        a0 = n_addr; o0 = n_out;
        or_mode = 1;
        send_cmd(18'h02000, 18'd20, acc);
        repeat (40) @(negedge clock);
        chk("credit_issued", n_addr - a0, MO);
        chk("credit_addr_valid", addr_valid, 0);
        chk("credit_out_valid", out_valid, 1);
        or_mode = 0;
        wait_done("credit", 400);
        chk("credit_addrs", n_addr - a0, 20);
        chk("credit_words", n_out - o0, 20);

        // Wrap-around
        a0 = n_addr;
        send_cmd(18'h3FFFE, 18'd4, acc);
        wait_done("wrap", 200);
        chk("wrap_addrs", n_addr - a0, 4);

        // Empty burst
        a0 = n_addr;
        send_cmd(18'h00123, 18'd0, acc);
        wait_done("empty", 20);
        chk("empty_addrs", n_addr - a0, 0);
        chk("empty_done_latency", done_cyc - acc, 1);

        // Backpressure
        a0 = n_addr; o0 = n_out;
        ar_rand = 1; or_mode = 2;
        send_cmd(18'h10000, 18'd100, acc);
        wait_done("bp", 4000);
        chk("bp_words", n_out - o0, 100);
        ar_rand = 0;

        // Reset mid-burst
        o0 = n_out;
        send_cmd(18'h00300, 18'd10, acc);
        t = 0;
        while (n_out - o0 < 5 && t < 400) begin @(negedge clock); t++; end
        chk("mid_reached_5", (n_out - o0 >= 5), 1);
        @(posedge clock); #1 reset_n = 0;
        @(posedge clock); #1 reset_n = 1;
        @(negedge clock);
        check_reset_outputs("midreset");
        or_mode = 0;
        t = 0;
        while (arb_q.size() != 0 && t < 100) begin @(negedge clock); t++; end
        chk("stray_drained", arb_q.size(), 0);
        repeat (4) @(negedge clock);
        chk("stray_no_output", out_valid, 0);
        a0 = n_addr; o0 = n_out;
        send_cmd(18'h00200, 18'd10, acc);
        wait_done("after_reset", 300);
        chk("after_reset_words", n_out - o0, 10);
        chk("after_reset_addrs", n_addr - a0, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
